fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the synchronous-read instruction memory (1-cycle read latency).

---
 rtl/fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a 1-cycle synchronous instruction memory with a 2-entry output FIFO.
// Optional misaligned-redirect trap (ERR state, fetch_misaligned port) enabled by FETCH_MISALIGN_CHK_EN.
module fetch_ctrl #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  fetch_halt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [31:0]           out_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic                  fetch_misaligned
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1
`ifdef FETCH_MISALIGN_CHK_EN
        , ERR  = 2'd2
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           fetch_pc_q, fetch_pc_d;
    logic                  inflight_v_q, inflight_v_d;
    logic [31:0]           inflight_pc_q, inflight_pc_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [31:0]           pc_mem_q [2];
    logic [31:0]           pc_mem_d [2];
    logic [DATA_WIDTH-1:0] instr_mem_q [2];
    logic [DATA_WIDTH-1:0] instr_mem_d [2];

    logic [31:0] redirect_pc_al;
    logic        redirect_ok;
    logic        push;
    logic        pop;
    logic        issue;
    logic [2:0]  occupancy;

`ifdef FETCH_MISALIGN_CHK_EN
    logic redirect_bad;
    assign redirect_bad     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_ok      = redirect_valid && !redirect_bad;
    assign fetch_misaligned = (state_q == ERR);
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign redirect_ok    = redirect_valid;
`endif

    assign redirect_pc_al = {redirect_pc[31:2], 2'b00};
    assign imem_addr      = redirect_valid ? redirect_pc[ADDR_WIDTH+1:2] : fetch_pc_q[ADDR_WIDTH+1:2];
    assign out_valid      = (count_q != 2'd0) && !redirect_valid;
    assign out_instr      = instr_mem_q[rd_ptr_q];
    assign out_pc         = pc_mem_q[rd_ptr_q];
    assign pop            = out_valid && out_ready;
    assign push           = inflight_v_q && !redirect_valid;

    // A same-cycle pop frees the slot the next returning word will need, which sustains one word per cycle.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_v_q} - {2'b00, pop};
    assign issue     = (state_q == RUN) && !redirect_valid && (occupancy < 3'd2);

    // NOTE: every _d takes its _q (or a safe value) as the first statement, so no path can infer a latch.
    always_comb begin
        state_d       = fetch_halt ? HALTED : RUN;
        fetch_pc_d    = fetch_pc_q;
        inflight_v_d  = issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d      = rd_ptr_q ^ pop;
        wr_ptr_d      = wr_ptr_q ^ push;
        pc_mem_d      = pc_mem_q;
        instr_mem_d   = instr_mem_q;
`ifdef FETCH_MISALIGN_CHK_EN
        if (state_q == ERR && !redirect_ok) state_d = ERR;
        if (redirect_bad)                   state_d = ERR;
`endif
        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end
        if (push) begin
            pc_mem_d[wr_ptr_q]    = inflight_pc_q;
            instr_mem_d[wr_ptr_q] = imem_rdata;
        end
        if (redirect_valid) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
        if (redirect_ok) begin
            if (state_q == RUN) begin
                inflight_v_d  = 1'b1;
                inflight_pc_d = redirect_pc_al;
                fetch_pc_d    = redirect_pc_al + 32'd4;
            end else begin
                fetch_pc_d    = redirect_pc_al;
            end
        end
    end

    // NOTE: state is updated only with <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            // NOTE: the two FIFO slots are reset so out_instr/out_pc read 0 after reset; deep RAMs would not be.
            for (int i = 0; i < 2; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            pc_mem_q      <= pc_mem_d;
            instr_mem_q   <= instr_mem_d;
        end
    end

    // A returning word must always find a free slot.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl with a behavioural 1-cycle memory holding word[i] = 0x13 + 0x80*i.
// The misalignment scenario compiles in when FETCH_MISALIGN_CHK_EN is defined.
`timescale 1ns/1ps
module tb_fetch_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata = '0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          fetch_halt = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [31:0]   out_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic          fetch_misaligned;
`endif

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_pc;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_halt     (fetch_halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        , .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h13 + ({22'b0, a} << 7);
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    // Every accepted transfer is matched against the next expected PC and its memory word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            acc_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no transfer", out_pc, out_instr);
            end else begin
                mon_pc = exp_q.pop_front();
                if (out_pc !== mon_pc || out_instr !== mem_word(mon_pc[AW+1:2])) begin
                    errors++;
                    $display("FAIL sb_data: got pc=%h instr=%h, required pc=%h instr=%h",
                             out_pc, out_instr, mon_pc, mem_word(mon_pc[AW+1:2]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fetch_halt = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        acc_cnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_acc(input int target, input int budget, output int cyc);
        cyc = 0;
        while (acc_cnt < target && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || imem_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_values: got valid=%b pc=%h instr=%h addr=%h, required 0 0 0 0",
                     out_valid, out_pc, out_instr, imem_addr);
        end
`ifdef FETCH_MISALIGN_CHK_EN
        checks++;
        if (fetch_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_misaligned: got %b, required 0", fetch_misaligned);
        end
`endif
        exp_q.delete();
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        out_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle_valid: got %b, required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL first_output_latency: got valid=%b pc=%h, required 1 00000000", out_valid, out_pc);
        end
        wait_acc(4, 20, cyc);
        checks++;
        if (acc_cnt != 4 || cyc != 4) begin
            errors++;
            $display("FAIL back_to_back: got %0d words in %0d cycles, required 4 in 4", acc_cnt, cyc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int cyc;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i >= 2) begin
                checks++;
                if (imem_addr !== 10'd2) begin
                    errors++;
                    $display("FAIL stall_addr: got %0d at cycle %0d, required 2", imem_addr, i);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL stall_head: got valid=%b pc=%h, required 1 00000000", out_valid, out_pc);
        end
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        out_ready = 1'b1;
        wait_acc(6, 30, cyc);
        checks++;
        if (acc_cnt != 6 || cyc != 6) begin
            errors++;
            $display("FAIL stall_release: got %0d words in %0d cycles, required 6 in 6", acc_cnt, cyc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect();
        int cyc;
        do_reset();
        exp_q.push_back(32'h0);
        out_ready = 1'b1;
        wait_acc(1, 10, cyc);
        out_ready = 1'b0;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
            errors++;
            $display("FAIL redirect_pre_head: got valid=%b pc=%h, required 1 00000004", out_valid, out_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 10'h10) begin
            errors++;
            $display("FAIL redirect_cycle: got valid=%b addr=%h, required 0 010", out_valid, imem_addr);
        end
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: got valid=%b, required 0", out_valid);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h40 + 32'(i * 4));
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
            errors++;
            $display("FAIL redirect_target: got valid=%b pc=%h, required 1 00000040", out_valid, out_pc);
        end
        out_ready = 1'b1;
        wait_acc(4, 20, cyc);
        checks++;
        if (acc_cnt != 4 || cyc != 3) begin
            errors++;
            $display("FAIL redirect_stream: got %0d words in %0d cycles, required 4 in 3", acc_cnt, cyc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_pop();
        int cyc;
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        out_ready = 1'b1;
        wait_acc(2, 12, cyc);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 10'h20) begin
            errors++;
            $display("FAIL redirect_pop_cycle: got valid=%b addr=%h, required 0 020", out_valid, imem_addr);
        end
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || acc_cnt != 2) begin
            errors++;
            $display("FAIL redirect_pop_discard: got valid=%b words=%0d, required 0 2", out_valid, acc_cnt);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h80 + 32'(i * 4));
        wait_acc(5, 20, cyc);
        checks++;
        if (acc_cnt != 5 || cyc != 4) begin
            errors++;
            $display("FAIL redirect_pop_stream: got %0d words in %0d cycles, required 5 in 4", acc_cnt, cyc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_halt();
        int cyc;
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        out_ready = 1'b1;
        wait_acc(2, 12, cyc);
        fetch_halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (imem_addr !== 10'd5) begin
                errors++;
                $display("FAIL halt_addr: got %0d at halt cycle %0d, required 5", imem_addr, i);
            end
        end
        checks++;
        if (acc_cnt != 5 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_drain: got words=%0d valid=%b, required 5 0", acc_cnt, out_valid);
        end
        fetch_halt = 1'b0;
        wait_acc(6, 20, cyc);
        checks++;
        if (acc_cnt != 6 || cyc != 4) begin
            errors++;
            $display("FAIL halt_resume: got %0d words after %0d cycles, required 6 after 4", acc_cnt, cyc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int cyc;
        do_reset();
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        out_ready = 1'b1;
        wait_acc(3, 20, cyc);
        out_ready = 1'b0;
        checks++;
        if (acc_cnt != 3) begin
            errors++;
            $display("FAIL pc_wrap: got %0d words, required 3", acc_cnt);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0FFC;
        tick();
        redirect_valid = 1'b0;
        exp_q.push_back(32'h0000_0FFC);
        exp_q.push_back(32'h0000_1000);
        out_ready = 1'b1;
        wait_acc(5, 20, cyc);
        out_ready = 1'b0;
        checks++;
        if (acc_cnt != 5) begin
            errors++;
            $display("FAIL addr_wrap: got %0d words, required 5", acc_cnt);
        end
`ifndef FETCH_MISALIGN_CHK_EN
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0062;
        tick();
        redirect_valid = 1'b0;
        exp_q.push_back(32'h0000_0060);
        out_ready = 1'b1;
        wait_acc(6, 20, cyc);
        out_ready = 1'b0;
        checks++;
        if (acc_cnt != 6) begin
            errors++;
            $display("FAIL lsb_drop: got %0d words, required 6", acc_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_full: got valid=%b, required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || imem_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got valid=%b instr=%h pc=%h addr=%h, required 0 0 0 0",
                     out_valid, out_instr, out_pc, imem_addr);
        end
        repeat (2) tick();
        exp_q.delete();
        acc_cnt = 0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_leak: got valid=%b, required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h13) begin
            errors++;
            $display("FAIL reset_mid_restart: got valid=%b pc=%h instr=%h, required 1 00000000 00000013",
                     out_valid, out_pc, out_instr);
        end
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        int cyc;
        do_reset();
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_cycle: got valid=%b, required 0", out_valid);
        end
        tick();
        redirect_valid = 1'b0;
        repeat (3) begin
            checks++;
            if (fetch_misaligned !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_err: got flag=%b valid=%b, required 1 0", fetch_misaligned, out_valid);
            end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h44;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fetch_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear: got flag=%b, required 0", fetch_misaligned);
        end
        exp_q.push_back(32'h44);
        out_ready = 1'b1;
        wait_acc(1, 10, cyc);
        out_ready = 1'b0;
        checks++;
        if (acc_cnt != 1) begin
            errors++;
            $display("FAIL misalign_recover: got %0d words, required 1", acc_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_halt();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d undelivered words, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
